// File: rtl/pipelined_cpu.sv
// pipelined_cpu: five-stage (IF/ID/EX/MEM/WB) 32-bit MIPS-subset core.
// Instruction memory, register file, data memory, hazard detection,
// forwarding and branch/jump flush logic live in this file. Programs and data
// are loaded through the memory arrays by hierarchical access.
// Ports:
//   clk_i   - system clock, all state updates on the rising edge
//   rst_i   - synchronous active-high reset (PC and pipeline registers only)
//   start_i - run enable; 0 freezes every piece of state
// Optional feature macro: FORWARDING_EN (defined = EX and branch operand
// forwarding; undefined = dependent instructions stall until the producer
// reaches WB).

package cpu_pkg;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        alu_op_e    alu_op;
        logic [4:0] dst;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
    } id_ex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  dst;
        logic [31:0] alu;
        logic [31:0] store;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  dst;
        logic [31:0] wdata;
    } mem_wb_t;
endpackage

module pc_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] pc_next,
    output logic [31:0] pc_o
);
    // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)     pc_o <= '0;
        else if (en) pc_o <= pc_next;
    end
endmodule

module instruction_memory (
    input  logic [7:0]  addr,
    output logic [31:0] instr
);
    logic [31:0] memory [0:255];
    assign instr = memory[addr];
endmodule

module register_file (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] register [0:31];

    // NOTE: storage arrays carry no reset; contents survive rst_i by design.
    always_ff @(posedge clk) begin
        if (we && wa != 5'd0) register[wa] <= wd;
    end

    // Write-before-read: the value being written this cycle is returned directly.
    assign rd1 = (ra1 == 5'd0) ? '0 : (we && wa == ra1) ? wd : register[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : (we && wa == ra2) ? wd : register[ra2];
endmodule

module data_memory (
    input  logic        clk,
    input  logic        we,
    input  logic [2:0]  word,
    input  logic [31:0] wd,
    output logic [31:0] rd
);
    logic [7:0] memory [0:31];

    always_ff @(posedge clk) begin
        if (we) begin
            memory[{word, 2'd0}] <= wd[7:0];
            memory[{word, 2'd1}] <= wd[15:8];
            memory[{word, 2'd2}] <= wd[23:16];
            memory[{word, 2'd3}] <= wd[31:24];
        end
    end

    assign rd = {memory[{word, 2'd3}], memory[{word, 2'd2}],
                 memory[{word, 2'd1}], memory[{word, 2'd0}]};
endmodule

module control import cpu_pkg::*; (
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output ctrl_t      ctrl,
    output logic       uses_rs,
    output logic       uses_rt,
    output logic       Branch_o,
    output logic       Jump_o
);
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        ctrl     = '0;
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        Branch_o = 1'b0;
        Jump_o   = 1'b0;
        case (op)
            6'h00: begin
                ctrl.reg_write = 1'b1;
                ctrl.dst       = rd;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
                case (funct)
                    6'h20:   ctrl.alu_op = ALU_ADD;
                    6'h22:   ctrl.alu_op = ALU_SUB;
                    6'h24:   ctrl.alu_op = ALU_AND;
                    6'h25:   ctrl.alu_op = ALU_OR;
                    6'h18:   ctrl.alu_op = ALU_MUL;
                    default: begin
                        ctrl.reg_write = 1'b0;
                        uses_rs        = 1'b0;
                        uses_rt        = 1'b0;
                    end
                endcase
            end
            6'h08: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.dst       = rt;
                uses_rs        = 1'b1;
            end
            6'h23: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.dst       = rt;
                uses_rs        = 1'b1;
            end
            6'h2B: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
            end
            6'h04: begin
                Branch_o = 1'b1;
                uses_rs  = 1'b1;
                uses_rt  = 1'b1;
            end
            6'h02:   Jump_o = 1'b1;
            default: ;
        endcase
        // A write to r0 is dropped here, so no hazard or forward ever sees r0.
        if (ctrl.dst == 5'd0) ctrl.reg_write = 1'b0;
    end
endmodule

module hazard_detection (
    input  logic       uses_rs,
    input  logic       uses_rt,
    input  logic       branch,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       ex_wr,
    input  logic       ex_load,
    input  logic [4:0] ex_dst,
    input  logic       mem_wr,
    input  logic       mem_load,
    input  logic [4:0] mem_dst,
    output logic       mux8select_o
);
    logic hit_ex, hit_mem, stall;

    assign hit_ex  = ex_wr  && ((uses_rs && rs == ex_dst)  || (uses_rt && rt == ex_dst));
    assign hit_mem = mem_wr && ((uses_rs && rs == mem_dst) || (uses_rt && rt == mem_dst));

`ifdef FORWARDING_EN
    // Load-use, and beq behind an EX producer (1 cycle) or a load (2 cycles).
    assign stall = (hit_ex && (ex_load || branch)) || (hit_mem && mem_load && branch);
`else
    assign stall = hit_ex || hit_mem;
`endif

    assign mux8select_o = !stall;
endmodule

module flush_or (
    input  logic a,
    input  logic b,
    output logic flush_o
);
    assign flush_o = a | b;
endmodule

module pipelined_cpu import cpu_pkg::*; (
    input logic clk_i,
    input logic rst_i,
    input logic start_i
);
    logic [31:0] pc, pc_plus4, pc_next, fetched, if_id_instr, if_id_pc4;
    logic [31:0] rf_a, rf_b, br_a, br_b, imm, op_a, op_b, alu_b, alu_y, load_data;
    logic [4:0]  rs, rt;
    logic        uses_rs, uses_rt, branch, jump, taken, no_stall, stall, go, flush, wb_we;
    ctrl_t       id_ctrl;
    id_ex_t      id_ex;
    ex_mem_t     ex_mem;
    mem_wb_t     mem_wb;

    // ---------------- IF ----------------
    pc_reg PC (.clk(clk_i), .rst(rst_i), .en(go), .pc_next(pc_next), .pc_o(pc));
    assign pc_plus4 = {pc[31:10], pc[9:0] + 10'd4};
    instruction_memory Instruction_Memory (.addr(pc[9:2]), .instr(fetched));

    // ---------------- ID ----------------
    assign rs  = if_id_instr[25:21];
    assign rt  = if_id_instr[20:16];
    assign imm = {{16{if_id_instr[15]}}, if_id_instr[15:0]};

    control Control (
        .op(if_id_instr[31:26]), .funct(if_id_instr[5:0]), .rt(rt), .rd(if_id_instr[15:11]),
        .ctrl(id_ctrl), .uses_rs(uses_rs), .uses_rt(uses_rt), .Branch_o(branch), .Jump_o(jump)
    );

    // Frozen or resetting cycles must not commit a write-back.
    assign wb_we = mem_wb.reg_write && start_i && !rst_i;
    register_file Registers (
        .clk(clk_i), .we(wb_we), .ra1(rs), .ra2(rt), .wa(mem_wb.dst), .wd(mem_wb.wdata),
        .rd1(rf_a), .rd2(rf_b)
    );

    hazard_detection HazardDetection (
        .uses_rs(uses_rs), .uses_rt(uses_rt), .branch(branch), .rs(rs), .rt(rt),
        .ex_wr(id_ex.ctrl.reg_write), .ex_load(id_ex.ctrl.mem_read), .ex_dst(id_ex.ctrl.dst),
        .mem_wr(ex_mem.reg_write), .mem_load(ex_mem.mem_read), .mem_dst(ex_mem.dst),
        .mux8select_o(no_stall)
    );
    assign stall = !no_stall;

`ifdef FORWARDING_EN
    // Only ALU results are forwarded into the comparator; loads are stalled to WB.
    assign br_a = (ex_mem.reg_write && !ex_mem.mem_read && ex_mem.dst == rs) ? ex_mem.alu : rf_a;
    assign br_b = (ex_mem.reg_write && !ex_mem.mem_read && ex_mem.dst == rt) ? ex_mem.alu : rf_b;
`else
    assign br_a = rf_a;
    assign br_b = rf_b;
`endif

    assign taken = branch && (br_a == br_b);
    assign go    = start_i && !stall;   // a stalled beq/j never redirects
    flush_or OR (.a(go && jump), .b(go && taken), .flush_o(flush));

    assign pc_next = jump  ? {if_id_pc4[31:28], if_id_instr[25:0], 2'b00} :
                     taken ? if_id_pc4 + {imm[29:0], 2'b00} : pc_plus4;

    // ---------------- EX ----------------
`ifdef FORWARDING_EN
    always_comb begin
        op_a = id_ex.a;
        op_b = id_ex.b;
        if (ex_mem.reg_write && ex_mem.dst == id_ex.rs)      op_a = ex_mem.alu;
        else if (mem_wb.reg_write && mem_wb.dst == id_ex.rs) op_a = mem_wb.wdata;
        if (ex_mem.reg_write && ex_mem.dst == id_ex.rt)      op_b = ex_mem.alu;
        else if (mem_wb.reg_write && mem_wb.dst == id_ex.rt) op_b = mem_wb.wdata;
    end
`else
    assign op_a = id_ex.a;
    assign op_b = id_ex.b;
`endif

    assign alu_b = id_ex.ctrl.alu_src ? id_ex.imm : op_b;

    always_comb begin
        case (id_ex.ctrl.alu_op)
            ALU_SUB: alu_y = op_a - alu_b;
            ALU_AND: alu_y = op_a & alu_b;
            ALU_OR:  alu_y = op_a | alu_b;
            ALU_MUL: alu_y = op_a * alu_b;
            default: alu_y = op_a + alu_b;
        endcase
    end

    // ---------------- MEM ----------------
    data_memory Data_Memory (
        .clk(clk_i), .we(ex_mem.mem_write && start_i && !rst_i),
        .word(ex_mem.alu[4:2]), .wd(ex_mem.store), .rd(load_data)
    );

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            id_ex       <= '0;
            ex_mem      <= '0;
            mem_wb      <= '0;
        end else if (start_i) begin
            if (!stall) begin
                if_id_instr <= flush ? '0 : fetched;
                if_id_pc4   <= pc_plus4;
            end
            if (stall) begin
                id_ex <= '0;
            end else begin
                id_ex.ctrl <= id_ctrl;
                id_ex.a    <= rf_a;
                id_ex.b    <= rf_b;
                id_ex.imm  <= imm;
                id_ex.rs   <= rs;
                id_ex.rt   <= rt;
            end
            ex_mem.reg_write <= id_ex.ctrl.reg_write;
            ex_mem.mem_read  <= id_ex.ctrl.mem_read;
            ex_mem.mem_write <= id_ex.ctrl.mem_write;
            ex_mem.dst       <= id_ex.ctrl.dst;
            ex_mem.alu       <= alu_y;
            ex_mem.store     <= op_b;
            mem_wb.reg_write <= ex_mem.reg_write;
            mem_wb.dst       <= ex_mem.dst;
            mem_wb.wdata     <= ex_mem.mem_read ? load_data : ex_mem.alu;
        end
    end
endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed testbench for pipelined_cpu: reset/start behaviour, ALU chain with
// a freeze/resume, load-use, store, branch/jump loop, dependent beq stalls and
// r0 writes. Expected stall counts follow the FORWARDING_EN build option.
module tb_pipelined_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int stalls, flushes;

    localparam logic [4:0] R0 = 5'd0, T0 = 5'd8, T1 = 5'd9, T2 = 5'd10, T3 = 5'd11,
                           T4 = 5'd12, T5 = 5'd13, T6 = 5'd14;

`ifdef FORWARDING_EN
    localparam int ALU_STALLS = 0, LU_STALLS = 1, BR_STALLS = 3;
    localparam logic [31:0] FREEZE_PC = 32'd16;
`else
    localparam int ALU_STALLS = 4, LU_STALLS = 2, BR_STALLS = 4;
    localparam logic [31:0] FREEZE_PC = 32'd12;
`endif

    pipelined_cpu dut (.clk_i(clk), .rst_i(rst), .start_i(start));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    task automatic clear_state();
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = '0;
        for (int i = 0; i < 32; i++)  dut.Registers.register[i] = '0;
        for (int i = 0; i < 32; i++)  dut.Data_Memory.memory[i] = '0;
    endtask

    // One reset edge with start low, then release and start running.
    task automatic launch();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        start   = 1'b1;
        stalls  = 0;
        flushes = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (dut.HazardDetection.mux8select_o == 1'b0) stalls++;
            if (dut.OR.flush_o == 1'b1) flushes++;
        end
    endtask

    initial begin
        // ---------- reset and start ----------
        clear_state();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_pc", dut.PC.pc_o, 32'd0);
        check("reset_flush", {31'd0, dut.OR.flush_o}, 32'd0);
        check("reset_mux8", {31'd0, dut.HazardDetection.mux8select_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_pc", dut.PC.pc_o, 32'd0);
        end
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("start_pc", dut.PC.pc_o, 32'(4 * k));
        end

        // ---------- ALU chain with freeze/resume ----------
        start = 1'b0;
        clear_state();
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, R0, T0, 16'd5);
        dut.Instruction_Memory.memory[1] = enc_i(6'h08, R0, T1, 16'd3);
        dut.Instruction_Memory.memory[2] = enc_r(T0, T1, T2, 6'h20);
        dut.Instruction_Memory.memory[3] = enc_r(T2, T1, T3, 6'h22);
        dut.Instruction_Memory.memory[4] = enc_r(T0, T1, T4, 6'h18);
        launch();
        run(4);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("freeze_pc", dut.PC.pc_o, FREEZE_PC);
        end
        start = 1'b1;
        run(14);
        check("alu_add", dut.Registers.register[T2], 32'd8);
        check("alu_sub", dut.Registers.register[T3], 32'd5);
        check("alu_mul", dut.Registers.register[T4], 32'd15);
        check("alu_stalls", 32'(stalls), 32'(ALU_STALLS));

        // ---------- load-use ----------
        start = 1'b0;
        clear_state();
        dut.Data_Memory.memory[0] = 8'h05;
        dut.Instruction_Memory.memory[0] = enc_i(6'h23, R0, T0, 16'd0);
        dut.Instruction_Memory.memory[1] = enc_r(T0, T0, T1, 6'h20);
        launch();
        run(12);
        check("lu_t0", dut.Registers.register[T0], 32'd5);
        check("lu_t1", dut.Registers.register[T1], 32'd10);
        check("lu_stalls", 32'(stalls), 32'(LU_STALLS));

        // ---------- store ----------
        start = 1'b0;
        clear_state();
        dut.Data_Memory.memory[0] = 8'hDD;
        dut.Data_Memory.memory[1] = 8'hCC;
        dut.Data_Memory.memory[2] = 8'hBB;
        dut.Data_Memory.memory[3] = 8'hAA;
        for (int i = 4; i < 8; i++) dut.Data_Memory.memory[i] = 8'hFF;
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, R0, T0, 16'd7);
        dut.Instruction_Memory.memory[1] = enc_i(6'h2B, R0, T0, 16'd4);
        launch();
        run(12);
        check("st_b4", {24'd0, dut.Data_Memory.memory[4]}, 32'h07);
        check("st_b5", {24'd0, dut.Data_Memory.memory[5]}, 32'h00);
        check("st_b6", {24'd0, dut.Data_Memory.memory[6]}, 32'h00);
        check("st_b7", {24'd0, dut.Data_Memory.memory[7]}, 32'h00);
        check("st_word0", {dut.Data_Memory.memory[3], dut.Data_Memory.memory[2],
                           dut.Data_Memory.memory[1], dut.Data_Memory.memory[0]}, 32'hAABBCCDD);

        // ---------- branch/jump loop ----------
        start = 1'b0;
        clear_state();
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, R0, T0, 16'd3);
        dut.Instruction_Memory.memory[1] = enc_i(6'h08, R0, T1, 16'd0);
        dut.Instruction_Memory.memory[2] = enc_i(6'h04, T0, R0, 16'd3);
        dut.Instruction_Memory.memory[3] = enc_i(6'h08, T1, T1, 16'd2);
        dut.Instruction_Memory.memory[4] = enc_i(6'h08, T0, T0, 16'hFFFF);
        dut.Instruction_Memory.memory[5] = enc_j(26'd2);
        dut.Instruction_Memory.memory[6] = enc_i(6'h04, R0, R0, 16'd1);
        dut.Instruction_Memory.memory[7] = enc_i(6'h08, R0, T5, 16'd9);
        dut.Instruction_Memory.memory[8] = enc_i(6'h08, R0, T6, 16'd4);
        launch();
        run(50);
        check("loop_t0", dut.Registers.register[T0], 32'd0);
        check("loop_t1", dut.Registers.register[T1], 32'd6);
        check("loop_t5", dut.Registers.register[T5], 32'd0);
        check("loop_t6", dut.Registers.register[T6], 32'd4);
        check("loop_flushes", 32'(flushes), 32'd5);

        // ---------- dependent beq stalls ----------
        start = 1'b0;
        clear_state();
        dut.Data_Memory.memory[0] = 8'h05;
        dut.Instruction_Memory.memory[0] = enc_i(6'h23, R0, T0, 16'd0);
        dut.Instruction_Memory.memory[1] = enc_i(6'h04, T0, R0, 16'd1);
        dut.Instruction_Memory.memory[2] = enc_i(6'h08, R0, T1, 16'd1);
        dut.Instruction_Memory.memory[3] = enc_i(6'h08, R0, T2, 16'd5);
        dut.Instruction_Memory.memory[4] = enc_i(6'h04, T2, T0, 16'd1);
        dut.Instruction_Memory.memory[5] = enc_i(6'h08, R0, T3, 16'd9);
        dut.Instruction_Memory.memory[6] = enc_i(6'h08, R0, T4, 16'd6);
        launch();
        run(20);
        check("br_t1", dut.Registers.register[T1], 32'd1);
        check("br_t3", dut.Registers.register[T3], 32'd0);
        check("br_t4", dut.Registers.register[T4], 32'd6);
        check("br_stalls", 32'(stalls), 32'(BR_STALLS));
        check("br_flushes", 32'(flushes), 32'd1);

        // ---------- r0 write ----------
        start = 1'b0;
        clear_state();
        dut.Registers.register[T0] = 32'h55;
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, R0, R0, 16'd3);
        dut.Instruction_Memory.memory[1] = enc_r(R0, R0, T0, 6'h20);
        launch();
        run(12);
        check("r0_reg", dut.Registers.register[0], 32'd0);
        check("r0_read", dut.Registers.register[T0], 32'd0);

        start = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
